// File: rtl/foc_telemetry_buf.sv
// rtl/foc_telemetry_buf.sv - decimated multi-channel telemetry capture FIFO
// Show-ahead FIFO with stop-when-full or overwrite-oldest policy and a sticky overflow flag.
module foc_telemetry_buf #(
  parameter int N_CH    = 4,
  parameter int DW      = 16,
  parameter int DEPTH   = 16,
  parameter int DECIM_W = 8
) (
  input  logic                      clk_50m,
  input  logic                      rstn,
  input  logic                      sample_en,
  input  logic [N_CH*DW-1:0]        sample_data,
  input  logic                      cfg_enable,
  input  logic [DECIM_W-1:0]        cfg_decim,
  input  logic                      cfg_mode,
  input  logic                      clear,
  input  logic                      pop,
  output logic [N_CH*DW-1:0]        rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [N_CH*DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [DECIM_W-1:0] cnt;

  logic capture;
  logic pop_ok;
  logic wr_en;
  logic rd_adv;
  logic drop;

  assign capture  = sample_en && cfg_enable && (cnt == '0);
  assign pop_ok   = pop && (level != '0);
  // A capture at full is only lost when neither a pop nor overwrite mode makes room.
  assign wr_en    = capture && (!full || pop_ok || cfg_mode);
  assign rd_adv   = pop_ok || (capture && full && cfg_mode);
  assign drop     = capture && full && !pop_ok;

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (level != '0);
  assign full     = (level == DEPTH_L);

  always_ff @(posedge clk_50m) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (!cfg_enable) begin
        cnt <= '0;
      end else if (sample_en) begin
        cnt <= (cnt == '0) ? cfg_decim : cnt - 1'b1;
      end

      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case ({wr_en, rd_adv})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_foc_telemetry_buf.sv
// tb/tb_foc_telemetry_buf.sv - directed bench for foc_telemetry_buf
module tb_foc_telemetry_buf;

  logic        clk_50m = 1'b0;
  logic        rstn = 1'b0;
  logic        sample_en = 1'b0;
  logic [63:0] sample_data = '0;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_decim = '0;
  logic        cfg_mode = 1'b0;
  logic        clear = 1'b0;
  logic        pop = 1'b0;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic        full;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  foc_telemetry_buf #(.N_CH(4), .DW(16), .DEPTH(16), .DECIM_W(8)) dut (
    .clk_50m(clk_50m), .rstn(rstn), .sample_en(sample_en), .sample_data(sample_data),
    .cfg_enable(cfg_enable), .cfg_decim(cfg_decim), .cfg_mode(cfg_mode), .clear(clear),
    .pop(pop), .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .full(full),
    .overflow(overflow)
  );

  always #10 clk_50m = ~clk_50m;

  // Channel k carries v with bits [15:14] set to k, so every lane is distinguishable.
  function automatic logic [63:0] mk(input logic [15:0] v);
    return {v ^ 16'hC000, v ^ 16'h8000, v ^ 16'h4000, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v);
    sample_data = mk(v);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #5;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    tick();
    rstn = 1'b1;
    cfg_enable = 1'b1;
    tick();

    // Every strobe captured, in-order readout.
    strobe(16'h0001);
    chk("first_level", 64'(level), 64'd1);
    chk("first_data", rd_data, mk(16'h0001));
    strobe(16'h0002);
    strobe(16'h0003);
    chk("d0_level", 64'(level), 64'd3);
    for (int i = 1; i <= 3; i++) begin
      chk("d0_pop_data", rd_data, mk(16'(i)));
      do_pop();
    end
    chk("d0_empty_valid", 64'(rd_valid), 64'd0);
    chk("d0_empty_level", 64'(level), 64'd0);

    // Pop while empty is ignored; capture+pop while empty stores one entry.
    do_pop();
    chk("empty_pop_level", 64'(level), 64'd0);
    chk("empty_pop_ovf", 64'(overflow), 64'd0);
    sample_data = mk(16'h000A);
    sample_en = 1'b1;
    pop = 1'b1;
    tick();
    sample_en = 1'b0;
    pop = 1'b0;
    chk("cap_pop_empty_level", 64'(level), 64'd1);
    chk("cap_pop_empty_data", rd_data, mk(16'h000A));
    do_pop();

    // Decimation by 3: strobes 1..9 keep 1, 4, 7.
    cfg_decim = 8'd2;
    for (int i = 1; i <= 9; i++) strobe(16'(i));
    chk("d2_level", 64'(level), 64'd3);
    chk("d2_e0", rd_data, mk(16'd1));
    do_pop();
    chk("d2_e1", rd_data, mk(16'd4));
    do_pop();
    chk("d2_e2", rd_data, mk(16'd7));
    do_pop();

    // Disabled capture is suppressed.
    cfg_enable = 1'b0;
    cfg_decim = 8'd0;
    strobe(16'h00EE);
    chk("disabled_level", 64'(level), 64'd0);
    cfg_enable = 1'b1;

    // Stop-when-full: 20 captures keep 1..16.
    cfg_mode = 1'b0;
    for (int i = 1; i <= 20; i++) strobe(16'(i));
    chk("m0_level", 64'(level), 64'd16);
    chk("m0_full", 64'(full), 64'd1);
    chk("m0_ovf", 64'(overflow), 64'd1);
    for (int i = 1; i <= 16; i++) begin
      chk("m0_pop_data", rd_data, mk(16'(i)));
      do_pop();
    end
    chk("m0_drained", 64'(rd_valid), 64'd0);
    chk("m0_ovf_sticky", 64'(overflow), 64'd1);
    pulse_clear();
    chk("clr_ovf", 64'(overflow), 64'd0);

    // Overwrite-oldest: 20 captures keep 5..20.
    cfg_mode = 1'b1;
    for (int i = 1; i <= 20; i++) strobe(16'(i));
    chk("m1_level", 64'(level), 64'd16);
    chk("m1_ovf", 64'(overflow), 64'd1);
    for (int i = 5; i <= 20; i++) begin
      chk("m1_pop_data", rd_data, mk(16'(i)));
      do_pop();
    end
    chk("m1_drained", 64'(level), 64'd0);
    pulse_clear();

    // Capture+pop at full: no overflow, both pointers advance.
    cfg_mode = 1'b0;
    for (int i = 'h21; i <= 'h30; i++) strobe(16'(i));
    sample_data = mk(16'h0031);
    sample_en = 1'b1;
    pop = 1'b1;
    tick();
    sample_en = 1'b0;
    pop = 1'b0;
    chk("fullpop_level", 64'(level), 64'd16);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    chk("fullpop_data", rd_data, mk(16'h0022));
    for (int i = 0; i < 16; i++) do_pop();
    do_pop();
    chk("underflow_level", 64'(level), 64'd0);
    chk("underflow_ovf", 64'(overflow), 64'd0);
    strobe(16'h0040);
    chk("underflow_ptr", rd_data, mk(16'h0040));
    pulse_clear();

    // Clear beats a coinciding strobe; level 5 with overflow set beforehand.
    for (int i = 1; i <= 17; i++) strobe(16'(i));
    for (int i = 0; i < 11; i++) do_pop();
    chk("pre_clr_level", 64'(level), 64'd5);
    chk("pre_clr_ovf", 64'(overflow), 64'd1);
    cfg_decim = 8'd3;
    sample_data = mk(16'h0099);
    sample_en = 1'b1;
    clear = 1'b1;
    tick();
    sample_en = 1'b0;
    clear = 1'b0;
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_ovf2", 64'(overflow), 64'd0);
    chk("clr_valid", 64'(rd_valid), 64'd0);

    // Decimation by 4 from a cleared counter: keep strobes 1, 5, 9.
    for (int i = 1; i <= 9; i++) strobe(16'(i));
    chk("d3_level", 64'(level), 64'd3);
    chk("d3_e0", rd_data, mk(16'd1));
    do_pop();
    chk("d3_e1", rd_data, mk(16'd5));
    do_pop();
    chk("d3_e2", rd_data, mk(16'd9));
    strobe(16'h0050);
    chk("pre_rst_level", 64'(level), 64'd1);

    // Asynchronous reset mid-stream acts without a clock edge.
    #3;
    rstn = 1'b0;
    #2;
    chk("async_level", 64'(level), 64'd0);
    chk("async_valid", 64'(rd_valid), 64'd0);
    chk("async_full", 64'(full), 64'd0);
    chk("async_ovf", 64'(overflow), 64'd0);
    tick();
    rstn = 1'b1;
    strobe(16'h0055);
    chk("post_rst_level", 64'(level), 64'd1);
    chk("post_rst_data", rd_data, mk(16'h0055));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
